// File: rtl/pair_sweeper_pkg.sv
// Shared definitions for the pair sweeper: FSM encoding, default operand
// ranges and the pair-count helper.
package pair_sweeper_pkg;

  localparam int X_W = 4;
  localparam int Y_W = 3;
  localparam int CNT_W = 6;
  localparam int RES_W = 7;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_REL     = 3'd4;
  localparam logic [2:0] ST_WAITRES = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam int DEF_X_MIN        = 1;
  localparam int DEF_X_MAX        = 15;
  localparam int DEF_Y_MIN        = 4;
  localparam int DEF_Y_MAX        = 7;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_HOLD_CYCLES  = 3;

  function automatic logic [RES_W-1:0] npairs(input int x_min, input int x_max,
                                              input int y_min, input int y_max);
    int n;
    n = (x_max - x_min + 1) * (y_max - y_min + 1);
    return n[RES_W-1:0];
  endfunction

endpackage

// File: rtl/pair_sweeper_if.sv
// Operand/result handshake between the sweeper (master) and the
// multiple-test unit (slave).
interface pair_sweeper_if;
  import pair_sweeper_pkg::*;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           dav_;
  logic           rfd;
  logic           m;
  logic           ok;

  modport master (output x, y, dav_, input rfd, m, ok);
  modport slave  (input x, y, dav_, output rfd, m, ok);

endinterface

// File: rtl/pair_sweeper_result_tally.sv
// Counts ok rising edges and the multiples among them; runs independently of
// the handshake FSM because ok may arrive before or after rfd rises.
module pair_sweeper_result_tally
  import pair_sweeper_pkg::*;
(
  input  logic             clock,
  input  logic             reset_,
  input  logic             clear,
  input  logic             enable,
  input  logic             ok,
  input  logic             m,
  output logic [RES_W-1:0] results,
  output logic [CNT_W-1:0] count
);

  logic ok_prev;
  logic ok_rise;

  assign ok_rise = ok & ~ok_prev;

  // A start load in the same clock as an ok edge wins: counters clear.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ok_prev <= 1'b0;
      results <= {RES_W{1'b0}};
      count   <= {CNT_W{1'b0}};
    end else begin
      ok_prev <= ok;
      if (clear) begin
        results <= {RES_W{1'b0}};
        count   <= {CNT_W{1'b0}};
      end else if (enable && ok_rise) begin
        results <= results + 7'd1;
        if (m && (count != 6'd63)) begin
          count <= count + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pair_sweeper.sv
// Sweeps every (x, y) pair in the configured range over the dav_/rfd
// handshake and reports how many pairs the downstream unit flagged as multiples.
module pair_sweeper
  import pair_sweeper_pkg::*;
#(
  parameter int X_MIN        = DEF_X_MIN,
  parameter int X_MAX        = DEF_X_MAX,
  parameter int Y_MIN        = DEF_Y_MIN,
  parameter int Y_MAX        = DEF_Y_MAX,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
)
(
  input  logic             clock,
  input  logic             reset_,
  input  logic             start,
  pair_sweeper_if.master   bus,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [X_W-1:0]   X_LO       = X_W'(X_MIN);
  localparam logic [X_W-1:0]   X_HI       = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_LO       = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]   Y_HI       = Y_W'(Y_MAX);
  localparam logic [7:0]       SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [RES_W-1:0] NPAIRS     = npairs(X_MIN, X_MAX, Y_MIN, Y_MAX);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [7:0]       phase;
  logic             phase_clr;
  logic             load;
  logic             advance;
  logic             last_pair;
  logic [X_W-1:0]   x_cur;
  logic [Y_W-1:0]   y_cur;
  logic             dav_cur;
  logic             done_cur;
  logic [RES_W-1:0] results;
  logic             tally_en;

  assign last_pair = (x_cur == X_HI) && (y_cur == Y_HI);
  assign tally_en  = (state != ST_IDLE) && (state != ST_DONE);

  // Next-state decode; phase keeps counting only while SETUP/HOLD dwell.
  always_comb begin
    state_nxt = state;
    phase_clr = 1'b1;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_SETUP;
        end else begin
          state_nxt = state;
        end
      end
      ST_SETUP: begin
        if (phase == SETUP_LAST) begin
          state_nxt = ST_REQ;
        end else begin
          phase_clr = 1'b0;
        end
      end
      ST_REQ: begin
        if (!bus.rfd) begin
          state_nxt = (HOLD_CYCLES == 0) ? ST_REL : ST_HOLD;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (phase == HOLD_LAST) begin
          state_nxt = ST_REL;
        end else begin
          phase_clr = 1'b0;
        end
      end
      ST_REL: begin
        if (bus.rfd && last_pair) begin
          state_nxt = ST_WAITRES;
        end else if (bus.rfd) begin
          advance   = 1'b1;
          state_nxt = ST_SETUP;
        end else begin
          state_nxt = ST_REL;
        end
      end
      ST_WAITRES: begin
        if (results == NPAIRS) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WAITRES;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // dav_ and done are registered from the next state so they switch with it.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state    <= ST_IDLE;
      phase    <= 8'd0;
      x_cur    <= {X_W{1'b0}};
      y_cur    <= {Y_W{1'b0}};
      dav_cur  <= 1'b1;
      done_cur <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_clr ? 8'd0 : phase + 8'd1;
      dav_cur  <= !((state_nxt == ST_REQ) || (state_nxt == ST_HOLD));
      done_cur <= (state_nxt == ST_DONE);
      if (load) begin
        x_cur <= X_LO;
        y_cur <= Y_LO;
      end else if (advance && (y_cur == Y_HI)) begin
        x_cur <= x_cur + 4'd1;
        y_cur <= Y_LO;
      end else if (advance) begin
        y_cur <= y_cur + 3'd1;
      end
    end
  end

  pair_sweeper_result_tally u_tally (
    .clock   (clock),
    .reset_  (reset_),
    .clear   (load),
    .enable  (tally_en),
    .ok      (bus.ok),
    .m       (bus.m),
    .results (results),
    .count   (count)
  );

  assign bus.x    = x_cur;
  assign bus.y    = y_cur;
  assign bus.dav_ = dav_cur;
  assign done     = done_cur;

endmodule

// File: tb/tb_pair_sweeper.sv
// Directed bench for pair_sweeper: a behavioural multiple-test responder with
// selectable ok timing, plus reset and single-pair corner sequences.
module tb_pair_sweeper;

  typedef struct {
    int mode;       // 0: ok with rfd rise, 1: ok 2 clocks before, 2: ok 5 clocks after
    bit poke;       // pulse start while the first request is pending
    int exp_count;
  } sweep_vec_t;

  logic       clock = 1'b0;
  logic       reset_;
  logic       start_a;
  logic       start_b;
  logic [5:0] count_a;
  logic [5:0] count_b;
  logic       done_a;
  logic       done_b;

  int         checks;
  int         errors;
  int         pend;
  logic       pm;
  bit         okhi;
  logic       pdav;
  logic [3:0] px;
  logic [2:0] py;
  sweep_vec_t vecs [3];

  pair_sweeper_if ifa ();
  pair_sweeper_if ifb ();

  always #5 clock = ~clock;

  pair_sweeper dut_a (
    .clock  (clock),
    .reset_ (reset_),
    .start  (start_a),
    .bus    (ifa),
    .count  (count_a),
    .done   (done_a)
  );

  pair_sweeper #(.X_MIN(6), .X_MAX(6), .Y_MIN(3), .Y_MAX(3)) dut_b (
    .clock  (clock),
    .reset_ (reset_),
    .start  (start_b),
    .bus    (ifb),
    .count  (count_b),
    .done   (done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One clock on the falling edge: services a delayed ok and checks x/y hold while dav_ is low.
  task automatic tick();
    @(negedge clock);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ifa.m  = pm;
        ifa.ok = 1'b1;
        okhi   = 1'b1;
      end
    end else if (okhi) begin
      ifa.ok = 1'b0;
      okhi   = 1'b0;
    end
    if (ifa.dav_ === 1'b0 && pdav === 1'b0) begin
      checks++;
      if (ifa.x !== px || ifa.y !== py) begin
        errors++;
        $display("FAIL xy_stable: x=%0d y=%0d, required x=%0d y=%0d", ifa.x, ifa.y, px, py);
      end
    end
    pdav = ifa.dav_;
    px   = ifa.x;
    py   = ifa.y;
  endtask

  task automatic run_sweep(input int mode, input bit poke, input int exp_count);
    int   xe;
    int   ye;
    int   cyc;
    int   hold;
    int   xv;
    int   yv;
    logic mv;
    xe = 1;
    ye = 4;
    for (int k = 0; k < 60; k++) begin
      cyc = 0;
      while (ifa.dav_ !== 1'b0 && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("request_in_time", 32'(cyc < 100), 1);
      if (cyc >= 100) return;
      chk("pair_x", 32'(ifa.x), xe);
      chk("pair_y", 32'(ifa.y), ye);
      if (poke && k == 0) begin
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_ignored_dav", 32'(ifa.dav_), 0);
        chk("start_ignored_x", 32'(ifa.x), xe);
        chk("start_ignored_y", 32'(ifa.y), ye);
        chk("start_ignored_done", 32'(done_a), 0);
      end
      xv = 32'(ifa.x);
      yv = 32'(ifa.y);
      tick();
      ifa.rfd = 1'b0;
      hold = 0;
      cyc  = 0;
      do begin
        tick();
        cyc++;
        if (ifa.dav_ === 1'b0) hold++;
      end while (ifa.dav_ === 1'b0 && cyc < 50);
      chk("hold_cycles", hold, 3);
      mv = (yv != 0) && ((xv % yv) == 0);
      case (mode)
        0: begin
          ifa.rfd = 1'b1;
          ifa.m   = mv;
          ifa.ok  = 1'b1;
          okhi    = 1'b1;
        end
        1: begin
          ifa.m  = mv;
          ifa.ok = 1'b1;
          tick();
          ifa.ok = 1'b0;
          tick();
          ifa.rfd = 1'b1;
        end
        default: begin
          ifa.rfd = 1'b1;
          pm      = mv;
          pend    = 5;
        end
      endcase
      if (ye == 7) begin
        ye = 4;
        xe++;
      end else begin
        ye++;
      end
    end
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("done_set", 32'(done_a), 1);
    chk("final_count", 32'(count_a), exp_count);
    repeat (3) tick();
    chk("count_stable", 32'(count_a), exp_count);
    chk("done_held", 32'(done_a), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    checks  = 0;
    errors  = 0;
    pend    = 0;
    pm      = 1'b0;
    okhi    = 1'b0;
    pdav    = 1'b1;
    px      = 4'd0;
    py      = 3'd0;
    reset_  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ifa.rfd = 1'b1;
    ifa.ok  = 1'b0;
    ifa.m   = 1'b0;
    ifb.rfd = 1'b1;
    ifb.ok  = 1'b0;
    ifb.m   = 1'b0;

    vecs[0] = '{mode: 0, poke: 1'b1, exp_count: 10};
    vecs[1] = '{mode: 1, poke: 1'b0, exp_count: 10};
    vecs[2] = '{mode: 2, poke: 1'b0, exp_count: 10};

    repeat (2) tick();
    chk("reset_dav", 32'(ifa.dav_), 1);
    chk("reset_x", 32'(ifa.x), 0);
    chk("reset_y", 32'(ifa.y), 0);
    chk("reset_count", 32'(count_a), 0);
    chk("reset_done", 32'(done_a), 0);
    reset_ = 1'b1;
    tick();

    // Reset while the first request is outstanding must release dav_ at once.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 0;
    while (ifa.dav_ !== 1'b0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("midreq_reached", 32'(ifa.dav_), 0);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_reset_dav", 32'(ifa.dav_), 1);
    chk("async_reset_x", 32'(ifa.x), 0);
    chk("async_reset_y", 32'(ifa.y), 0);
    chk("async_reset_count", 32'(count_a), 0);
    chk("async_reset_done", 32'(done_a), 0);
    tick();
    reset_ = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("restart_x", 32'(ifa.x), 1);
      chk("restart_y", 32'(ifa.y), 4);
      chk("restart_done", 32'(done_a), 0);
      chk("restart_count", 32'(count_a), 0);
      chk("restart_dav", 32'(ifa.dav_), 1);
      run_sweep(vecs[i].mode, vecs[i].poke, vecs[i].exp_count);
    end

    // Single-pair range: exactly one handshake (6,3), which is a multiple.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 0;
    while (ifb.dav_ !== 1'b0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("single_req", 32'(ifb.dav_), 0);
    chk("single_x", 32'(ifb.x), 6);
    chk("single_y", 32'(ifb.y), 3);
    tick();
    ifb.rfd = 1'b0;
    cyc = 0;
    while (ifb.dav_ !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("single_release", 32'(ifb.dav_), 1);
    ifb.rfd = 1'b1;
    ifb.m   = 1'b1;
    ifb.ok  = 1'b1;
    tick();
    ifb.ok = 1'b0;
    cyc = 0;
    while (done_b !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("single_done", 32'(done_b), 1);
    chk("single_count", 32'(count_b), 1);
    cyc = 0;
    repeat (10) begin
      tick();
      if (ifb.dav_ === 1'b0) cyc++;
    end
    chk("single_no_second_req", cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_sweeper.md
Name: pair_sweeper

Overview:
Upstream sequencer for the multiple-test unit. It sweeps every (x, y) operand pair in a configured range and delivers each pair over the dav_/rfd handshake. It collects the m result on each ok pulse and reports how many pairs were multiples. It replaces the hand-driven producer/consumer loops used in system-level runs.

Parameters:
X_MIN, 1, first x value (4-bit)
X_MAX, 15, last x value; X_MIN <= X_MAX
Y_MIN, 4, first y value (3-bit, nonzero)
Y_MAX, 7, last y value; Y_MIN <= Y_MAX
SETUP_CYCLES, 1, clocks x/y are held stable before dav_ falls (>= 1)
HOLD_CYCLES, 3, clocks dav_ stays low after rfd is seen low (>= 0)

Ports:
clock  in  1  system clock, rising edge
reset_  in  1  asynchronous, active-low reset
start  in  1  begin sweep; sampled only in IDLE or DONE
x  out  4  operand x to the multiple-test unit
y  out  3  operand y to the multiple-test unit
dav_  out  1  data valid, active low
rfd  in  1  ready for data from the multiple-test unit
m  in  1  result: 1 when x is a multiple of y
ok  in  1  result strobe; m is valid on its rising edge
count  out  6  number of pairs with m=1 in the current sweep
done  out  1  sweep complete, count final

Behaviour:
- Reset (async, reset_=0): x=0, y=0, dav_=1, count=0, done=0, state IDLE, all internal counters cleared. Reset mid-sweep aborts the sweep; dav_ returns to 1 immediately, not at the next edge.
- Pair order: y is the inner loop, x the outer. Sequence (X_MIN,Y_MIN), (X_MIN,Y_MIN+1) .. (X_MIN,Y_MAX), (X_MIN+1,Y_MIN) ... (X_MAX,Y_MAX). NPAIRS = (X_MAX-X_MIN+1)*(Y_MAX-Y_MIN+1), at most 60 for 4/3-bit ranges.
- FSM states:
  - IDLE: wait for start=1. Load x=X_MIN, y=Y_MIN, clear count and the result counter, go to SETUP.
  - SETUP: dav_=1, x/y stable. After SETUP_CYCLES clocks go to REQ.
  - REQ: dav_=0. Wait for rfd=0 sampled, then go to HOLD.
  - HOLD: dav_=0 for HOLD_CYCLES clocks, then go to REL.
  - REL: dav_=1. Wait for rfd=1 sampled. If this was the last pair, go to WAITRES. Otherwise advance x/y in the same cycle and go to SETUP.
  - WAITRES: wait until the result counter equals NPAIRS, then go to DONE.
  - DONE: done=1. start=1 restarts the sweep as from IDLE, clearing done and count in the same edge.
- x/y change only on the REL->SETUP transition or on a start load. They never change while dav_=0.
- start is ignored in SETUP/REQ/HOLD/REL/WAITRES.
- Result tally: it runs independently of the FSM because ok may rise before or after rfd rises.
  - ok is registered once; a rising edge is ok=1 with previous ok=0.
  - On each rising edge: result counter +1; count +1 when m=1.
  - Edges seen while in IDLE or DONE are ignored.
  - An ok edge and a start load on the same clock: the load wins and the counters clear.
- count saturates at 63 (unreachable for legal parameters).
- rfd already 0 when entering REQ: REQ is left on the first sampled clock.
- rfd already 1 when entering REL: REL is left on the first sampled clock.
- Inputs are synchronous to clock; no synchronisers are required.

Decomposition:
- Shared package: FSM state encoding (IDLE, SETUP, REQ, HOLD, REL, WAITRES, DONE), default range constants, and an NPAIRS helper function.
- One sub-module, result_tally: ok edge detector, result counter and count register, with clear and enable inputs driven by the FSM.

Test Plan:
- Reset with dav_ low mid-REQ -> dav_=1, x=0, y=0, count=0, done=0 before the next clock edge.
- Default parameters, start pulse, real multiple-test unit downstream -> 60 handshakes in order (1,4),(1,5)..(15,7). done=1 with count=10 (y=4:3, y=5:3, y=6:2, y=7:2).
- Behavioural downstream asserting ok 2 clocks before rfd rises, and separately 5 clocks after -> count=10 and done in both cases, with no lost or double-counted results.
- Bench checker on every clock while dav_=0 -> x/y never change, and dav_ holds low for HOLD_CYCLES=3 clocks after rfd falls.
- start pulsed during REQ, then again after done -> first pulse has no effect; second clears count to 0, drops done, and restarts at (1,4).
- X_MIN=6, X_MAX=6, Y_MIN=Y_MAX=3 -> exactly one handshake with x=6, y=3, m=1; done=1 with count=1.
